// File: rtl/lsu.sv
// Load/store unit: drives the data-RAM port for one request at a time, and
// masks and extends load data taken from the RAM's registered, byte-shifted read port.
module lsu #(
  parameter logic [31:0] ADDR_LIMIT  = 32'h800,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadAddr,
    StLoadCapture,
    StStore,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic        req_err;
  logic [31:0] wdata_masked;
  logic [31:0] load_ext;

  // Request legality, evaluated on the live request so errors never reach memory.
  always_comb begin
    misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      case (req_funct3_i[1:0])
        2'b01:   misaligned = req_addr_i[0];
        2'b10:   misaligned = |req_addr_i[1:0];
        default: misaligned = 1'b0;
      endcase
    end
    req_err = (req_addr_i >= ADDR_LIMIT) || misaligned;
    if (req_store_i) begin
      req_err = req_err || req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11);
    end else begin
      req_err = req_err || (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
  end

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   wdata_masked = {24'h0, req_wdata_i[7:0]};
      2'b01:   wdata_masked = {16'h0, req_wdata_i[15:0]};
      default: wdata_masked = req_wdata_i;
    endcase
  end

  // mem_rdata_i is already shifted down to the addressed byte.
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      3'b100:  load_ext = {24'h0, mem_rdata_i[7:0]};
      3'b001:  load_ext = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      3'b101:  load_ext = {16'h0, mem_rdata_i[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          wdata_d  = wdata_masked;
          funct3_d = req_funct3_i;
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err)          state_d = StResp;
          else if (req_store_i) state_d = StStore;
          else                  state_d = StLoadAddr;
        end
      end
      StLoadAddr:    state_d = StLoadCapture;
      StLoadCapture: begin
        rdata_d = load_ext;
        state_d = StResp;
      end
      StStore:       state_d = StResp;
      StResp:        if (resp_ready_i) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we_o = 3'b000;
    if (state_q == StStore) begin
      case (funct3_q[1:0])
        2'b10:   mem_we_o = 3'b001;
        2'b01:   mem_we_o = 3'b010;
        2'b00:   mem_we_o = 3'b100;
        default: mem_we_o = 3'b000;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_err_o   = err_q;
  assign resp_rdata_o = rdata_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      funct3_q <= 3'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a behavioural data RAM, a byte-level shadow model feeding a
// scoreboard queue, and directed load/store/error/backpressure/reset sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [2:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_err_o   (resp_err),
    .resp_rdata_o (resp_rdata),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // Data RAM: word array indexed by addr[10:2], registered read shifted by byte offset.
  logic [31:0] ram [512];
  logic        ram_clr;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
    end else begin
      if (mem_we == 3'b001) ram[mem_addr[10:2]] <= mem_wdata;
      if (mem_we == 3'b010) ram[mem_addr[10:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
      if (mem_we == 3'b100) ram[mem_addr[10:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
    end
    mem_rdata <= ram[mem_addr[10:2]] >> {mem_addr[1:0], 3'b000};
  end

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] shadow [2048];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour at byte granularity; updates the shadow for legal stores.
  task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
    logic        bad;
    logic [10:0] i;
    logic [31:0] w;
    bad = (a >= 32'h800);
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
    if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
    if (!st && (f3 inside {3'b011, 3'b110, 3'b111})) bad = 1'b1;
    i = a[10:0];
    e.err   = bad;
    e.rdata = 32'h0;
    if (bad) begin
      e.lat = 4'd1;
    end else if (st) begin
      e.lat = 4'd2;
      shadow[i] = wd[7:0];
      if (f3 != 3'b000) shadow[i + 11'd1] = wd[15:8];
      if (f3 == 3'b010) begin
        shadow[i + 11'd2] = wd[23:16];
        shadow[i + 11'd3] = wd[31:24];
      end
    end else begin
      e.lat = 4'd3;
      w = {shadow[i + 11'd3], shadow[i + 11'd2], shadow[i + 11'd1], shadow[i]};
      case (f3)
        3'b000:  e.rdata = {{24{w[7]}}, w[7:0]};
        3'b100:  e.rdata = {24'h0, w[7:0]};
        3'b001:  e.rdata = {{16{w[15]}}, w[15:0]};
        3'b101:  e.rdata = {16'h0, w[15:0]};
        default: e.rdata = w;
      endcase
    end
  endtask

  // Called just after a negedge. Drives one request, follows it to its response,
  // optionally stalls the response for 'hold' cycles, then completes the handshake.
  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t        e;
    logic        got;
    logic [2:0]  we_acc;
    logic [2:0]  we_exp;
    logic [31:0] wmask;
    int          we_n;
    int          lat;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    got = req_ready;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    predict(st, f3, a, wd, e);
    sb_q.push_back(e);

    wmask  = (f3 == 3'b000) ? 32'h0000_00ff : (f3 == 3'b001) ? 32'h0000_ffff : 32'hffff_ffff;
    we_exp = (f3 == 3'b000) ? 3'b100 : (f3 == 3'b001) ? 3'b010 : 3'b001;
    got = 1'b0; we_acc = 3'b000; we_n = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_we != 3'b000) begin
        we_n++;
        we_acc = mem_we;
        check({tag, "_mem_addr"}, mem_addr, a);
        check({tag, "_mem_wdata"}, mem_wdata, wd & wmask);
      end
      if (resp_valid) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, "_resp_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_err"}, 32'(resp_err), 32'(e.err));
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_we_cycles"}, 32'(we_n), (st && !e.err) ? 32'd1 : 32'd0);
    check({tag, "_we_value"}, 32'(we_acc), (st && !e.err) ? 32'(we_exp) : 32'd0);

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  int seen;

  initial begin
    resetn     = 1'b0;
    ram_clr    = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 2048; i++) shadow[i] = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    ram_clr = 1'b0;
    resetn  = 1'b1;
    @(negedge clk);

    issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hdead_beef, 0);
    issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 0);

    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h80f0_7f81, 0);
    issue("lb_20", 1'b0, 3'b000, 32'h20, 32'h0, 0);
    issue("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0, 0);
    issue("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 0);
    issue("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 0);
    issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 0);

    issue("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0, 0);
    issue("sh_21_mis", 1'b1, 3'b001, 32'h21, 32'h1234_ffff, 0);
    issue("sb_800_oor", 1'b1, 3'b000, 32'h800, 32'h0000_00aa, 0);
    issue("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 0);
    issue("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h5555_5555, 0);
    issue("lw_20_back", 1'b0, 3'b010, 32'h20, 32'h0, 0);
    issue("lw_00_back", 1'b0, 3'b010, 32'h0, 32'h0, 0);

    issue("sb_7ff", 1'b1, 3'b000, 32'h7ff, 32'h0000_00c3, 0);
    issue("lbu_7ff", 1'b0, 3'b100, 32'h7ff, 32'h0, 0);
    issue("sw_7fc", 1'b1, 3'b010, 32'h7fc, 32'h1234_5678, 0);
    issue("lw_7fc", 1'b0, 3'b010, 32'h7fc, 32'h0, 0);
    issue("lw_7fe_mis", 1'b0, 3'b010, 32'h7fe, 32'h0, 0);

    issue("lw_bp", 1'b0, 3'b010, 32'h10, 32'h0, 5);

    // Reset lands on the edge that would move LOAD_ADDR to LOAD_CAPTURE.
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    check("rstld_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstld_req_ready", 32'(req_ready), 32'd1);
    check("rstld_mem_we", 32'(mem_we), 32'd0);
    resetn = 1'b1;
    seen = 0;
    resp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    resp_ready = 1'b0;
    check("rstld_no_resp", 32'(seen), 32'd0);
    issue("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 0);

    issue("sb_30", 1'b1, 3'b000, 32'h30, 32'hffff_ff5a, 0);
    issue("lbu_30", 1'b0, 3'b100, 32'h30, 32'h0, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
